seq_divider: RTL and testbench

- Multi-cycle restoring integer divider for the CPU execute stage, serving DIV/DIVU-class instructions.
- Each iteration does one trial subtraction, using the same add-in-subtract-mode principle as the ALU adder slices: add the inverted operand with carry-in 1; carry-out 1 means no borrow.
- Start/busy/done handshake toward the pipeline control; results are held stable until the next accepted start.

---
 rtl/div_pkg.sv | 23 ++
 rtl/div_trial_sub.sv | 29 ++
 rtl/seq_divider.sv | 169 ++++++++++++++++
 tb/tb_seq_divider.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding,
// counter sizing and the divide-by-zero quotient constant.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PREP = 2'd1,
    ITER = 2'd2,
    FIX  = 2'd3
  } div_state_e;

  localparam int DIV_WIDTH_DEF = 32;
  localparam int DIV_MAX_WIDTH = 64;
  localparam int DIV_CNT_W     = $clog2(DIV_WIDTH_DEF);

  // Wide enough for any supported WIDTH; the divider takes the low bits.
  localparam logic [DIV_MAX_WIDTH-1:0] DIV_ZERO_QUOT = '1;

  function automatic int div_cnt_width(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/div_trial_sub.sv
// Trial subtractor: a - b computed as a + ~b + 1 with a rippled carry chain;
// the final carry-out high means the subtraction did not borrow.
module div_trial_sub #(
  parameter int N = 33
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         no_borrow
);

  logic [N:0] w_carry;

  assign w_carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      logic w_b_inv;
      assign w_b_inv        = ~b[gi];
      assign diff[gi]       = a[gi] ^ w_b_inv ^ w_carry[gi];
      assign w_carry[gi+1]  = (a[gi] & w_b_inv) | (a[gi] & w_carry[gi]) |
                              (w_b_inv & w_carry[gi]);
    end
  endgenerate

  assign no_borrow = w_carry[N];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider (signed/unsigned) with start/busy/done
// handshake; one quotient bit per cycle, sign fix-up in a final cycle.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int               CNT_W    = div_cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] Q_DIVZ   = DIV_ZERO_QUOT[WIDTH-1:0];

  div_state_e       r_state;
  div_state_e       w_state_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_signed;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_prem;
  logic [CNT_W-1:0] r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_busy;
  logic             r_dz_done;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_quot;
  logic [WIDTH-1:0] r_rem_out;

  logic             w_accept;
  logic             w_b_zero;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_no_borrow;
  logic [WIDTH:0]   w_rem_sel;
  logic             w_sel_msb_unused;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;
  logic             w_in_fix;

  assign w_accept = (r_state == IDLE) && start && !r_busy;
  assign w_b_zero = (r_b == '0);
  assign w_in_fix = (r_state == FIX);

  // Negating MIN wraps back to MIN, which read as unsigned is exactly 2^(W-1).
  assign w_a_mag = (r_signed && r_a[WIDTH-1]) ? (~r_a + WIDTH'(1)) : r_a;
  assign w_b_mag = (r_signed && r_b[WIDTH-1]) ? (~r_b + WIDTH'(1)) : r_b;

  assign w_shift = {r_prem, r_dvd[WIDTH-1]};

  div_trial_sub #(
    .N (WIDTH + 1)
  ) u_trial (
    .a         (w_shift),
    .b         ({1'b0, r_dvs}),
    .diff      (w_diff),
    .no_borrow (w_no_borrow)
  );

  // Either choice is below the divisor, so the top bit is always zero.
  assign w_rem_sel        = w_no_borrow ? w_diff : w_shift;
  assign w_sel_msb_unused = w_rem_sel[WIDTH];

  assign w_q_fix = r_neg_q ? (~r_dvd + WIDTH'(1))  : r_dvd;
  assign w_r_fix = r_neg_r ? (~r_prem + WIDTH'(1)) : r_prem;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: if (w_accept) w_state_next = PREP;
      PREP: w_state_next = w_b_zero ? IDLE : ITER;
      ITER: if (r_cnt == '0) w_state_next = FIX;
      FIX:  w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a        <= '0;
      r_b        <= '0;
      r_signed   <= 1'b0;
      r_dvd      <= '0;
      r_dvs      <= '0;
      r_prem     <= '0;
      r_cnt      <= '0;
      r_neg_q    <= 1'b0;
      r_neg_r    <= 1'b0;
      r_busy     <= 1'b0;
      r_dz_done  <= 1'b0;
      r_div_zero <= 1'b0;
      r_quot     <= '0;
      r_rem_out  <= '0;
    end else begin
      r_dz_done <= 1'b0;
      // busy drops at the end of the done cycle
      if (done) r_busy <= 1'b0;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a        <= dividend;
            r_b        <= divisor;
            r_signed   <= is_signed;
            r_busy     <= 1'b1;
            r_div_zero <= 1'b0;
          end
        end
        PREP: begin
          if (w_b_zero) begin
            r_quot     <= Q_DIVZ;
            r_rem_out  <= r_a;
            r_div_zero <= 1'b1;
            r_dz_done  <= 1'b1;
          end else begin
            r_dvd   <= w_a_mag;
            r_dvs   <= w_b_mag;
            r_neg_q <= r_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
            r_neg_r <= r_signed & r_a[WIDTH-1];
            r_prem  <= '0;
            r_cnt   <= CNT_INIT;
          end
        end
        ITER: begin
          r_prem <= w_rem_sel[WIDTH-1:0];
          r_dvd  <= {r_dvd[WIDTH-2:0], w_no_borrow};
          if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
        end
        FIX: begin
          r_quot    <= w_q_fix;
          r_rem_out <= w_r_fix;
        end
        default: ;
      endcase
    end
  end

  // During FIX the fixed-up result drives the outputs directly and is
  // captured into the hold registers on the same edge that leaves FIX.
  assign busy      = r_busy;
  assign done      = w_in_fix | r_dz_done;
  assign quotient  = w_in_fix ? w_q_fix : r_quot;
  assign remainder = w_in_fix ? w_r_fix : r_rem_out;
  assign div_zero  = r_div_zero;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomised checks of seq_divider (WIDTH=32) using an
// expected-result queue popped when the done pulse appears.
module tb_seq_divider;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_zero;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dz;
    int          lat;
    string       tag;
  } exp_t;

  exp_t sb[$];

  seq_divider #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Truncating division on magnitudes; remainder follows the dividend sign.
  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                input logic s,
                                output logic [31:0] q, output logic [31:0] r);
    logic [63:0] am, bm, qm, rm;
    logic        nq, nr;
    nr = s & a[31];
    nq = s & (a[31] ^ b[31]);
    am = {32'd0, (s && a[31]) ? (~a + 32'd1) : a};
    bm = {32'd0, (s && b[31]) ? (~b + 32'd1) : b};
    qm = am / bm;
    rm = am % bm;
    q  = nq ? (~qm[31:0] + 32'd1) : qm[31:0];
    r  = nr ? (~rm[31:0] + 32'd1) : rm[31:0];
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [31:0] eq, input logic [31:0] er, input logic edz,
                          input int lat, input string tag, input bit push);
    exp_t e;
    dividend  = a;
    divisor   = b;
    is_signed = s;
    start     = 1'b1;
    if (push) begin
      e.q = eq; e.r = er; e.dz = edz; e.lat = lat; e.tag = tag;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for done, counting cycles after the start edge; optionally pulses
  // a conflicting start while the operation is in flight.
  task automatic run_wait(input int pulse_at);
    exp_t e;
    int   n;
    bit   seen;
    n    = 0;
    seen = 0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      if (done) begin
        seen = 1;
      end else begin
        if (n == pulse_at) begin
          start = 1'b1; dividend = 32'd9; divisor = 32'd3; is_signed = 1'b0;
        end
        if (n == pulse_at + 1) start = 1'b0;
      end
    end
    e = sb.pop_front();
    chk({e.tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      chk({e.tag, "_latency"},   32'(n), 32'(e.lat));
      chk({e.tag, "_quotient"},  quotient, e.q);
      chk({e.tag, "_remainder"}, remainder, e.r);
      chk({e.tag, "_div_zero"},  32'(div_zero), 32'(e.dz));
      chk({e.tag, "_busy_done"}, 32'(busy), 32'd1);
      $display("TXN %s lat=%0d q=%h r=%h dz=%0d", e.tag, n, quotient, remainder, div_zero);
      @(negedge clk);
      chk({e.tag, "_busy_after"}, 32'(busy), 32'd0);
      chk({e.tag, "_done_after"}, 32'(done), 32'd0);
      chk({e.tag, "_q_held"},     quotient, e.q);
      chk({e.tag, "_r_held"},     remainder, e.r);
    end
  endtask

  initial begin
    logic [31:0] ra, rb, rq, rr;
    logic        rs;
    int          dcnt;

    rst_n = 1'b0; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_quotient", quotient, 32'd0);
    chk("rst_remainder", remainder, 32'd0);
    chk("rst_div_zero", 32'(div_zero), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    start_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0, 34, "u100_7", 1);
    run_wait(0);
    start_op(32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 34, "s_m7_2", 1);
    run_wait(0);
    start_op(32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1, 1'b0, 34, "s_7_m2", 1);
    run_wait(0);
    start_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'd1, 32'd0, 1'b0, 34, "u_max_max", 1);
    run_wait(0);
    start_op(32'h1234, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234, 1'b1, 2, "div0", 1);
    run_wait(0);
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 1'b0, 34, "s_min_m1", 1);
    run_wait(0);
    start_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'h8000_0000, 1'b0, 34, "u_min_max", 1);
    run_wait(0);
    start_op(32'hFFFF_FFF9, 32'd2, 1'b0, 32'h7FFF_FFFC, 32'd1, 1'b0, 34, "u_fff9_2", 1);
    run_wait(0);
    start_op(32'd12345, 32'd100, 1'b0, 32'd123, 32'd45, 1'b0, 34, "busy_ignore", 1);
    run_wait(5);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = (i < 3) ? 32'($urandom_range(1, 1000)) : $urandom;
      if (i % 2 == 1) rb = ~rb + 32'd1;
      if (rb == 32'd0) rb = 32'd1;
      rs = 1'(i % 3 != 0);
      model(ra, rb, rs, rq, rr);
      start_op(ra, rb, rs, rq, rr, 1'b0, 34, $sformatf("rand%0d", i), 1);
      run_wait(0);
    end

    // Reset mid-operation: abort with no done pulse, outputs cleared.
    dcnt = 0;
    start_op(32'd1000, 32'd3, 1'b0, 32'd0, 32'd0, 1'b0, 0, "abort", 0);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_quotient", quotient, 32'd0);
    chk("abort_remainder", remainder, 32'd0);
    chk("abort_div_zero", 32'(div_zero), 32'd0);
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("abort_no_done", 32'(dcnt), 32'd0);
    $display("TXN abort done_pulses=%0d", dcnt);

    start_op(32'd50, 32'd8, 1'b0, 32'd6, 32'd2, 1'b0, 34, "after_abort", 1);
    run_wait(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
